// File: rtl/segment_decoder_hexa.sv
// -----------------------------------------------------------------------------
// segment_decoder_hexa
//
// Purpose:
//   Watches an active-low seven-segment pattern and accepts it once it has been
//   sampled unchanged STABLE_CYCLES times in a row. Each accepted pattern is
//   decoded into a hex digit and offered to a consumer through a one-entry
//   valid/ready output register. The all-off pattern (blank) is accepted
//   silently. Any other pattern that is not a hex glyph is offered with oErr
//   set and oData = 0.
//
// Ports:
//   iClk      in   1  clock; all state updates on the rising edge
//   iRst_n    in   1  synchronous active-low reset
//   iSeg      in   7  segment pattern, active-low, [6:0] = g f e d c b a
//   iReady    in   1  consumer ready (only looked at while a result is pending)
//   oValid    out  1  decoded result pending
//   oData     out  4  decoded hex digit
//   oErr      out  1  pending result is not a legal glyph (qualifies oValid)
//   oOverrun  out  1  sticky: a pattern was accepted while a result was pending
//                     and could not be handed over; cleared only by reset
// -----------------------------------------------------------------------------
module segment_decoder_hexa #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [6:0] iSeg,
    input  logic       iReady,
    output logic       oValid,
    output logic [3:0] oData,
    output logic       oErr,
    output logic       oOverrun
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);
    localparam logic [6:0] BLANK   = 7'b1111111;

    // Glyph table, digit 0 in the least significant 7 bits.
    localparam logic [16*7-1:0] GLYPHS = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // D
        7'b1000110,  // C
        7'b0000011,  // B
        7'b0001000,  // A
        7'b0011000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [6:0] last_reg;
    logic [3:0] run_reg, run_next;
    logic [3:0] data_reg, data_next;
    logic       err_reg, err_next;
    logic       overrun_reg, overrun_next;

    logic [15:0] match;
    logic [3:0]  dec_data;
    logic        dec_err;
    logic        accept;
    logic        load;

    // ------------------------------------------------------------------
    // Glyph decode of the current input (only used on acceptance, when the
    // input equals the last sample anyway).
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (iSeg == GLYPHS[gi*7 +: 7]);
        end
    endgenerate

    always_comb begin
        dec_data = 4'h0;
        dec_err  = ~(|match);
        for (int i = 0; i < 16; i++) begin
            if (match[i]) begin
                dec_data = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stability run counter. It saturates at RUN_MAX, so acceptance fires
    // only on the step into RUN_MAX; a held pattern is not re-accepted until
    // a change restarts the run at 1.
    // ------------------------------------------------------------------
    always_comb begin
        run_next = run_reg;
        if (iSeg != last_reg) begin
            run_next = 4'd1;
        end else if (run_reg != RUN_MAX) begin
            run_next = run_reg + 4'd1;
        end
    end

    assign accept = (run_next == RUN_MAX) && (run_reg != RUN_MAX);
    assign load   = accept && (iSeg != BLANK);

    // ------------------------------------------------------------------
    // State register (plus sampling and datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_reg   <= S_EMPTY;
            last_reg    <= BLANK;
            run_reg     <= RUN_MAX;
            data_reg    <= 4'h0;
            err_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_reg    <= iSeg;
            run_reg     <= run_next;
            data_reg    <= data_next;
            err_reg     <= err_next;
            overrun_reg <= overrun_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        err_next     = err_reg;
        overrun_next = overrun_reg;
        case (state_reg)
            S_EMPTY: begin
                if (load) begin
                    state_next = S_FULL;
                    data_next  = dec_data;
                    err_next   = dec_err;
                end
            end
            S_FULL: begin
                if (iReady) begin
                    // Pending result is handed over this cycle; a result
                    // accepted in the same cycle takes its place.
                    if (load) begin
                        data_next = dec_data;
                        err_next  = dec_err;
                    end else begin
                        state_next = S_EMPTY;
                    end
                end else if (load) begin
                    // No room: the new pattern is dropped and flagged.
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = S_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: straight from registers, no path from iSeg/iReady.
    // ------------------------------------------------------------------
    always_comb begin
        oValid   = (state_reg == S_FULL);
        oData    = data_reg;
        oErr     = err_reg;
        oOverrun = overrun_reg;
    end

endmodule

// File: tb/tb_segment_decoder_hexa.sv
// -----------------------------------------------------------------------------
// tb_segment_decoder_hexa
//
// Directed bench for segment_decoder_hexa with STABLE_CYCLES = 4. Inputs are
// driven 1 time unit after a rising edge and outputs are sampled there too, so
// each check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_segment_decoder_hexa;

    logic       iClk;
    logic       iRst_n;
    logic [6:0] iSeg;
    logic       iReady;
    logic       oValid;
    logic [3:0] oData;
    logic       oErr;
    logic       oOverrun;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] P0    = 7'b1000000;
    localparam logic [6:0] P2    = 7'b0100100;
    localparam logic [6:0] P3    = 7'b0110000;
    localparam logic [6:0] P4    = 7'b0011001;
    localparam logic [6:0] P8    = 7'b0000000;
    localparam logic [6:0] PA    = 7'b0001000;
    localparam logic [6:0] PC    = 7'b1000110;
    localparam logic [6:0] PF    = 7'b0001110;
    localparam logic [6:0] PBAD  = 7'b1111110;
    localparam logic [6:0] BLANK = 7'b1111111;

    segment_decoder_hexa #(
        .STABLE_CYCLES(4)
    ) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iSeg    (iSeg),
        .iReady  (iReady),
        .oValid  (oValid),
        .oData   (oData),
        .oErr    (oErr),
        .oOverrun(oOverrun)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic v, input logic [3:0] d,
                             input logic e, input logic o);
        check({tag, ".valid"},   8'(oValid),   8'(v));
        check({tag, ".data"},    8'(oData),    8'(d));
        check({tag, ".err"},     8'(oErr),     8'(e));
        check({tag, ".overrun"}, 8'(oOverrun), 8'(o));
    endtask

    initial begin
        iRst_n = 1'b0;
        iSeg   = BLANK;
        iReady = 1'b1;

        // Reset state
        tick();
        tick();
        check_all("reset", 1'b0, 4'h0, 1'b0, 1'b0);

        // Blank held across reset release: never accepted
        iRst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("blank_hold.valid", 8'(oValid), 8'd0);
        end

        // '2' held from edge 1: valid after edge 4 only, for one cycle
        iSeg = P2;
        tick();
        check("two_e1.valid", 8'(oValid), 8'd0);
        tick();
        check("two_e2.valid", 8'(oValid), 8'd0);
        tick();
        check("two_e3.valid", 8'(oValid), 8'd0);
        tick();
        check_all("two_e4", 1'b1, 4'h2, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("two_hold.valid", 8'(oValid), 8'd0);
        end

        // Toggling 3/4 every 2 cycles: nothing accepted
        for (int k = 0; k < 10; k++) begin
            iSeg = (k % 2 == 0) ? P3 : P4;
            tick();
            check("toggle.valid", 8'(oValid), 8'd0);
            tick();
            check("toggle.valid", 8'(oValid), 8'd0);
        end
        // Hold '4': two samples already seen, two more complete the run
        tick();
        check("four_s3.valid", 8'(oValid), 8'd0);
        tick();
        check_all("four_s4", 1'b1, 4'h4, 1'b0, 1'b0);
        tick();
        check("four_after.valid", 8'(oValid), 8'd0);

        // Illegal glyph
        iSeg = PBAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bad_wait.valid", 8'(oValid), 8'd0);
        end
        tick();
        check_all("bad", 1'b1, 4'h0, 1'b1, 1'b0);
        tick();
        check("bad_after.valid", 8'(oValid), 8'd0);

        // Blank after a pattern: accepted silently
        iSeg = BLANK;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("blank.valid", 8'(oValid), 8'd0);
        end
        check("blank.overrun", 8'(oOverrun), 8'd0);

        // Overrun: A accepted, C accepted while A pending with no ready
        iReady = 1'b0;
        iSeg   = PA;
        for (int i = 0; i < 3; i++) tick();
        check("a_wait.valid", 8'(oValid), 8'd0);
        tick();
        check_all("a_acc", 1'b1, 4'hA, 1'b0, 1'b0);
        iSeg = PC;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("a_stable", 1'b1, 4'hA, 1'b0, 1'b0);
        end
        tick();
        check_all("c_dropped", 1'b1, 4'hA, 1'b0, 1'b1);
        tick();
        check_all("c_hold", 1'b1, 4'hA, 1'b0, 1'b1);
        iReady = 1'b1;
        tick();
        check("a_xfer.valid", 8'(oValid), 8'd0);
        check("a_xfer.overrun", 8'(oOverrun), 8'd1);
        tick();
        check("a_done.valid", 8'(oValid), 8'd0);

        // Reset clears sticky overrun
        iRst_n = 1'b0;
        iSeg   = BLANK;
        tick();
        iRst_n = 1'b1;
        check_all("reset2", 1'b0, 4'h0, 1'b0, 1'b0);

        // Acceptance of F in the same cycle as a transfer of 8
        iReady = 1'b0;
        iSeg   = P8;
        for (int i = 0; i < 4; i++) tick();
        check_all("eight_acc", 1'b1, 4'h8, 1'b0, 1'b0);
        iSeg = PF;
        for (int i = 0; i < 3; i++) tick();
        check_all("f_pending", 1'b1, 4'h8, 1'b0, 1'b0);
        iReady = 1'b1;
        tick();
        check_all("f_swap", 1'b1, 4'hF, 1'b0, 1'b0);
        tick();
        check("f_xfer.valid", 8'(oValid), 8'd0);
        check("f_xfer.overrun", 8'(oOverrun), 8'd0);

        // Reset while a result is pending; held '0' needs 4 fresh samples
        iReady = 1'b0;
        iSeg   = P0;
        for (int i = 0; i < 4; i++) tick();
        check_all("zero_acc", 1'b1, 4'h0, 1'b0, 1'b0);
        iRst_n = 1'b0;
        tick();
        check_all("reset3", 1'b0, 4'h0, 1'b0, 1'b0);
        iRst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("zero_rewait.valid", 8'(oValid), 8'd0);
        end
        tick();
        check_all("zero_reacc", 1'b1, 4'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segment_decoder_hexa.md
SEGMENT_DECODER_HEXA -- requirements
Module: segment_decoder_hexa

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (legal 2..15), the number of consecutive identical samples needed to accept a segment pattern.
REQ-002 SHALL have port iClk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port iRst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 SHALL have port iSeg, input, 7, segment pattern, active-low (0 = lit), bit order [6:0] = g f e d c b a.
REQ-005 SHALL have port iReady, input, 1, consumer ready.
REQ-006 SHALL have port oValid, output, 1, decoded result available.
REQ-007 SHALL have port oData, output, 4, decoded hex digit.
REQ-008 SHALL have port oErr, output, 1, accepted pattern is not a legal hex glyph; qualifies oValid.
REQ-009 SHALL have port oOverrun, output, 1, sticky flag: a pattern was accepted while a previous result was still pending.

Function
REQ-010 SHALL decode these exact patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-011 SHALL register iSeg every cycle into a last-sample register; run counter: iSeg != last sample -> run=1; iSeg == last sample -> run=min(run+1, STABLE_CYCLES).
REQ-012 SHALL accept a pattern exactly once per stable run, in the cycle the run counter becomes STABLE_CYCLES (it can only do so again after the run counter is restarted by a change).
REQ-013 Latency: a pattern first sampled at edge 1 and held through edge STABLE_CYCLES SHALL give oValid=1 immediately after edge STABLE_CYCLES.
REQ-014 Blank pattern 1111111 SHALL be accepted silently: no oValid, no oErr, no overrun.
REQ-015 Any other pattern not listed in REQ-010 SHALL be emitted with oValid=1, oErr=1, oData=4'h0.
REQ-016 FSM states: S_EMPTY (no result pending, oValid=0) and S_FULL (oValid=1).
REQ-017 S_EMPTY -> S_FULL on a non-blank acceptance, loading oData/oErr.
REQ-018 S_FULL -> S_EMPTY on a cycle with iReady=1 (transfer), unless a new acceptance occurs in the same cycle.
REQ-019 Acceptance with transfer in the same cycle SHALL load the new result and stay in S_FULL; oOverrun unaffected.
REQ-020 Acceptance in S_FULL without iReady SHALL discard the new pattern, keep oData/oErr unchanged, and set oOverrun.
REQ-021 oValid, oData and oErr SHALL remain stable while oValid=1 and iReady=0.
REQ-022 iReady SHALL be ignored in S_EMPTY.
REQ-023 oOverrun SHALL be cleared only by reset.
REQ-024 All outputs SHALL be registered; no combinational path from iSeg or iReady to outputs.

Reset
REQ-025 iRst_n=0 at a rising edge SHALL set: state S_EMPTY, oValid=0, oData=4'h0, oErr=0, oOverrun=0, last sample=1111111, run=STABLE_CYCLES.
REQ-026 Reset mid-run or in S_FULL SHALL discard the pending result and partial run; a pattern held across reset release needs STABLE_CYCLES fresh matching samples, or none if it is 1111111.

Verification
REQ-027 STABLE_CYCLES=4, iReady=1, iSeg=0100100 held from edge 1 -> oValid=1, oData=4'h2, oErr=0 after edge 4 only, for one cycle; no re-emission while held.
REQ-028 iSeg toggles 0110000/0011001 every 2 cycles for 20 cycles, then holds 0011001 -> oValid only after 4 stable samples of the held value, oData=4'h4.
REQ-029 iSeg=1111110 held -> oValid=1, oErr=1, oData=4'h0; iSeg=1111111 held -> no oValid.
REQ-030 iReady=0, accept 0001000 (A) then 1000110 (C) -> oData stays 4'hA, oOverrun=1; iReady=1 -> one transfer of A, then oValid=0.
REQ-031 oValid=1 with iReady=1 in the same cycle a new pattern 0001110 is accepted -> next cycle oValid=1, oData=4'hF, oOverrun=0.
REQ-032 iRst_n=0 for one edge while oValid=1 -> all outputs 0, then a held 1000000 needs 4 new samples before oData=4'h0 is presented with oValid=1.
